core_mem_system: RTL and testbench
==================================

Name: core_mem_system

Overview:
- Memory and MMIO slave that sits directly downstream of the core's memory port.
- Consumes `pc_to_mem`, `mem_addr`, `st_data` and `we`; returns `ld_data_for_inst` and `ld_data` after exactly `LOAD_LATENCY` cycles.
- Backs a unified instruction/data word RAM.
- Decodes a small MMIO window holding a UART TX FIFO and a UART RX FIFO, each with a valid/ready stream to the serial front-ends.

Parameters:
- `LOAD_LATENCY`, 1, read-data latency in cycles (>=1); must equal the core's load-latency parameter.
- `MEM_WORDS`, 4096, RAM depth in 64-bit words (power of two).
- `MMIO_BASE`, `'hFFFF_0000`, byte address of MMIO window (64-byte aligned).
- `FIFO_DEPTH`, 16, entries per UART FIFO (power of two, >=2).

Ports:
- `clk`  in  1  clock
- `rstn`  in  1  reset, asynchronous, active-low
- `pc_to_mem`  in  `ADDR_W`  instruction fetch byte address
- `mem_addr`  in  `ADDR_W`  data byte address
- `st_data`  in  `DATA_W`  store data
- `we`  in  `DATA_W/8`  byte-lane write enables
- `ld_data_for_inst`  out  `DATA_W`  fetch word
- `ld_data`  out  `DATA_W`  load word
- `tx_data`  out  8  byte to UART transmitter
- `tx_valid`  out  1  TX FIFO non-empty
- `tx_ready`  in  1  transmitter accepts byte
- `rx_data`  in  8  byte from UART receiver
- `rx_valid`  in  1  receiver byte available
- `rx_ready`  out  1  RX FIFO not full

Behaviour:
- Clock and reset: single clock `clk`; `rstn` asynchronous active-low.
  - On reset: `ld_data` = 0, `ld_data_for_inst` = 0, all latency-pipeline stages 0, both FIFOs empty, `tx_valid` = 0, `rx_ready` = 1, overflow flag = 0.
  - RAM contents are not reset.
  - Reset mid-transfer discards FIFO contents and in-flight reads.
- Byte order is big-endian within a word.
  - Byte offset k (addr[2:0] = k) maps to bits [63-8k:56-8k].
  - That offset is written by `we[7-k]`.
  - Word index = addr[log2(MEM_WORDS)+2:3]; higher RAM address bits are ignored (aliasing/wrap).
- Region decode: MMIO when addr[ADDR_W-1:6] == MMIO_BASE[ADDR_W-1:6], otherwise RAM. Fetches are always RAM.
- Reads:
  - Both ports sample the address every cycle; no read enable.
  - The result appears on the output exactly `LOAD_LATENCY` rising edges later.
  - Stage 1 is the RAM registered read; remaining stages are a shift register.
  - The region-select bit travels with the data so the final mux picks RAM or MMIO.
- Writes:
  - A RAM write occurs at the rising edge when `we` != 0 and the address is RAM; only enabled lanes change.
  - Same-cycle read of the same word on either port is read-first (returns old data).
  - A read issued on the next cycle sees the new data.
- MMIO map (offsets from `MMIO_BASE`):
  - 0x00 RX_DATA (read): bits [7:0] = RX FIFO head, 0 if empty; no side effect.
  - 0x08 STATUS (read):
    - bit0 tx_full
    - bit1 rx_nonempty
    - bit2 tx_overflow (sticky)
    - other bits 0.
  - 0x10 TX_DATA (write, any `we` != 0): pushes lane for byte offset 7, i.e. `st_data[7:0]`, into the TX FIFO.
    - If full, the byte is dropped and tx_overflow is set.
  - 0x18 RX_POP (write, any `we` != 0): pops the RX FIFO; ignored if empty.
  - Other offsets: reads return 0, writes are ignored.
  - MMIO writes never modify RAM.
- MMIO read values are captured in the issue cycle (pre-edge state) and then pipelined like RAM data.
- TX stream:
  - `tx_data` = FIFO head; `tx_valid` = !empty.
  - Pop occurs when `tx_valid && tx_ready`.
  - Simultaneous push and pop on a full FIFO: the push is still dropped (full sampled pre-edge).
- RX stream:
  - `rx_ready` = !full; push occurs when `rx_valid && rx_ready`.
  - Simultaneous push and pop are both honoured; count is unchanged.
- FIFOs: circular pointers with wrap at `FIFO_DEPTH` and an occupancy counter 0..FIFO_DEPTH.

Decomposition:
- Shared package/header (`common_params.h`) additions:
  - `MMIO_RX_DATA_OFS`, `MMIO_STATUS_OFS`, `MMIO_TX_DATA_OFS`, `MMIO_RX_POP_OFS`
  - STATUS bit indices
  - `BYTE_LANE(k)` lane-to-bit mapping macro
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH), instantiated twice:
  - ports push/push_data/pop/head/empty/full
  - asynchronous active-low reset

Test Plan:
- Reset held then released with `pc_to_mem` = 0 -> `ld_data_for_inst` = 0 until the first read, `tx_valid` = 0, `rx_ready` = 1.
- Write RAM word at 0x40 with `st_data` = 0x0123456789ABCDEF, `we` = 0xFF, then load 0x40 next cycle -> `ld_data` = 0x0123456789ABCDEF exactly `LOAD_LATENCY` cycles later; fetch of 0x40 gives the same word.
- Partial store `we` = 0x80 with `st_data` = 0xAA00_0000_0000_0000 to 0x40 -> reload gives 0xAA23456789ABCDEF; same-cycle fetch of 0x40 returns the old word.
- With `tx_ready` = 0, push 17 bytes 0x00..0x10 to TX_DATA -> STATUS reads 0x5 (full + overflow); then `tx_ready` = 1 drains 0x00..0x0F in order, `tx_valid` drops after 16 beats.
- Drive `rx_data` = 0x41 with `rx_valid` for one cycle -> STATUS bit1 = 1, RX_DATA = 0x41; store to RX_POP -> STATUS bit1 = 0; a further RX_POP has no effect.
- Store to `MEM_WORDS`*8+0x40 aliases 0x40; store to `MMIO_BASE`+0x20 leaves RAM and FIFOs unchanged and reads back 0.

Source files
------------

// File: rtl/core_mem_system_pkg.sv
// Shared widths, MMIO register offsets, STATUS bit positions and the
// big-endian byte-lane mapping used by the memory/MMIO slave.
package core_mem_system_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int BYTES_W = DATA_W / 8;

  typedef logic [DATA_W-1:0] word_t;

  // Offsets from the MMIO base; decode is on 8-byte word granularity.
  localparam logic [5:0] MMIO_RX_DATA_OFS = 6'h00;
  localparam logic [5:0] MMIO_STATUS_OFS  = 6'h08;
  localparam logic [5:0] MMIO_TX_DATA_OFS = 6'h10;
  localparam logic [5:0] MMIO_RX_POP_OFS  = 6'h18;

  localparam int STAT_TX_FULL     = 0;
  localparam int STAT_RX_NONEMPTY = 1;
  localparam int STAT_TX_OVERFLOW = 2;

  // Big-endian: byte offset k lives in bits [63-8k:56-8k]; returns the LSB.
  function automatic int byte_lane_lsb(input int k);
    return DATA_W - 8 - 8 * k;
  endfunction

endpackage

// File: rtl/core_mem_system_sync_fifo.sv
// Single-clock circular FIFO with occupancy counter. Pushes into a full
// FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = store_q[rd_ptr_q];

  // Next pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (!push_ok && pop_ok) count_d = count_q - CNT_ONE;
  end

  // Pointer and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since the counter gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) store_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/core_mem_system.sv
// Unified instruction/data RAM plus a small UART MMIO window, returning
// fetch and load words a fixed number of cycles after the address.
module core_mem_system
  import core_mem_system_pkg::*;
#(
  parameter int               LOAD_LATENCY = 1,
  parameter int               MEM_WORDS    = 4096,
  parameter logic [ADDR_W-1:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int               FIFO_DEPTH   = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [ADDR_W-1:0]   pc_to_mem,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W/8-1:0] we,
  output logic [DATA_W-1:0]   ld_data_for_inst,
  output logic [DATA_W-1:0]   ld_data,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  word_t          mem_q [MEM_WORDS];
  logic [IDX_W-1:0] d_idx, i_idx;
  logic           is_mmio, wr_any, ram_we, tx_push_req, rx_pop_req;
  logic [5:0]     mmio_ofs;
  logic           tx_empty, tx_full, rx_empty, rx_full;
  logic [7:0]     rx_head;
  logic           tx_ovf_q;
  word_t          mmio_rd;

  // Each stage carries RAM data, MMIO data and the region bit; the mux is at the end.
  word_t d_ram_q  [LOAD_LATENCY];
  word_t d_mmio_q [LOAD_LATENCY];
  logic  d_sel_q  [LOAD_LATENCY];
  word_t i_ram_q  [LOAD_LATENCY];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr[2:0], pc_to_mem[2:0], pc_to_mem[ADDR_W-1:IDX_W+3]};

  assign d_idx       = mem_addr[IDX_W+2:3];
  assign i_idx       = pc_to_mem[IDX_W+2:3];
  assign is_mmio     = (mem_addr[ADDR_W-1:6] == MMIO_BASE[ADDR_W-1:6]);
  assign mmio_ofs    = {mem_addr[5:3], 3'b000};
  assign wr_any      = |we;
  assign ram_we      = wr_any && !is_mmio;
  assign tx_push_req = wr_any && is_mmio && (mmio_ofs == MMIO_TX_DATA_OFS);
  assign rx_pop_req  = wr_any && is_mmio && (mmio_ofs == MMIO_RX_POP_OFS);
  assign tx_valid    = !tx_empty;
  assign rx_ready    = !rx_full;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (tx_push_req),
    .push_data (st_data[7:0]),
    .pop       (tx_valid && tx_ready),
    .head      (tx_data),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop_req),
    .head      (rx_head),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  // MMIO read value from pre-edge FIFO/flag state.
  always_comb begin
    mmio_rd = '0;
    if (mmio_ofs == MMIO_RX_DATA_OFS) begin
      mmio_rd[7:0] = rx_empty ? 8'h00 : rx_head;
    end else if (mmio_ofs == MMIO_STATUS_OFS) begin
      mmio_rd[STAT_TX_FULL]     = tx_full;
      mmio_rd[STAT_RX_NONEMPTY] = !rx_empty;
      mmio_rd[STAT_TX_OVERFLOW] = tx_ovf_q;
    end
  end

  // Sticky overflow: a TX push arriving while the FIFO is already full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                      tx_ovf_q <= 1'b0;
    else if (tx_push_req && tx_full) tx_ovf_q <= 1'b1;
  end

  // RAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int k = 0; k < BYTES_W; k++) begin
        if (we[BYTES_W-1-k])
          mem_q[d_idx][byte_lane_lsb(k) +: 8] <= st_data[byte_lane_lsb(k) +: 8];
      end
    end
  end

  // Read pipeline: stage 0 is the registered (read-first) RAM read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LOAD_LATENCY; i++) begin
        d_ram_q[i]  <= '0;
        d_mmio_q[i] <= '0;
        d_sel_q[i]  <= 1'b0;
        i_ram_q[i]  <= '0;
      end
    end else begin
      d_ram_q[0]  <= mem_q[d_idx];
      d_mmio_q[0] <= mmio_rd;
      d_sel_q[0]  <= is_mmio;
      i_ram_q[0]  <= mem_q[i_idx];
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        d_ram_q[i]  <= d_ram_q[i-1];
        d_mmio_q[i] <= d_mmio_q[i-1];
        d_sel_q[i]  <= d_sel_q[i-1];
        i_ram_q[i]  <= i_ram_q[i-1];
      end
    end
  end

  assign ld_data = d_sel_q[LOAD_LATENCY-1] ? d_mmio_q[LOAD_LATENCY-1]
                                           : d_ram_q[LOAD_LATENCY-1];
  assign ld_data_for_inst = i_ram_q[LOAD_LATENCY-1];

endmodule

// File: tb/tb_core_mem_system.sv
// Scoreboard bench: the driver predicts each cycle's load/fetch words and
// accepted TX bytes from a word-array/queue model; a monitor compares them
// when the DUT presents them.
module tb_core_mem_system;

  localparam int          LAT   = 2;
  localparam int          WORDS = 4096;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'hFFFF_0000;

  logic        clk, rstn;
  logic [31:0] pc_to_mem, mem_addr;
  logic [63:0] st_data, ld_data_for_inst, ld_data;
  logic [7:0]  we, tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  core_mem_system #(
    .LOAD_LATENCY (LAT),
    .MEM_WORDS    (WORDS),
    .MMIO_BASE    (BASE),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .pc_to_mem        (pc_to_mem),
    .mem_addr         (mem_addr),
    .st_data          (st_data),
    .we               (we),
    .ld_data_for_inst (ld_data_for_inst),
    .ld_data          (ld_data),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .rx_ready         (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [63:0] d;
    logic [63:0] d_mask;
    logic [63:0] i;
    logic [63:0] i_mask;
    int          due;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] tx_sb[$];

  // Reference model: word array with per-byte "written" flags, FIFOs as queues.
  logic [63:0] m_ram   [WORDS];
  logic [7:0]  m_known [WORDS];
  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic        m_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] lane_mask(input logic [7:0] kb);
    logic [63:0] m = '0;
    for (int j = 0; j < 8; j++) if (kb[j]) m[8*j +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic bit in_mmio(input logic [31:0] a);
    return (a >> 6) == (BASE >> 6);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 8) % WORDS);
  endfunction

  task automatic step(input logic [31:0] pc, input logic [31:0] da, input logic [63:0] sd,
                      input logic [7:0] w, input logic txr, input logic rxv, input logic [7:0] rxd);
    exp_t       e;
    logic [7:0] tmp;
    bit tx_full_pre, tx_ne_pre, rx_full_pre, rx_ne_pre;
    int ofs;
    @(posedge clk); #1;
    pc_to_mem = pc; mem_addr = da; st_data = sd; we = w;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    tx_full_pre = (m_tx.size() == DEPTH);
    tx_ne_pre   = (m_tx.size() > 0);
    rx_full_pre = (m_rx.size() == DEPTH);
    rx_ne_pre   = (m_rx.size() > 0);
    ofs = int'(da - BASE) / 8;
    if (in_mmio(da)) begin
      e.d_mask = '1;
      e.d = '0;
      if (ofs == 0 && rx_ne_pre) e.d[7:0] = m_rx[0];
      if (ofs == 1) e.d = {61'd0, m_ovf, rx_ne_pre, tx_full_pre};
    end else begin
      e.d      = m_ram[widx(da)];
      e.d_mask = lane_mask(m_known[widx(da)]);
    end
    e.i      = m_ram[widx(pc)];
    e.i_mask = lane_mask(m_known[widx(pc)]);
    e.due    = edge_cnt + LAT;
    sb_q.push_back(e);
    if (txr && tx_ne_pre) tmp = m_tx.pop_front();
    if (w != 0 && !in_mmio(da)) begin
      for (int j = 0; j < 8; j++)
        if (w[j]) m_ram[widx(da)][8*j +: 8] = sd[8*j +: 8];
      m_known[widx(da)] = m_known[widx(da)] | w;
    end
    if (w != 0 && in_mmio(da) && ofs == 2) begin
      if (tx_full_pre) m_ovf = 1'b1;
      else begin
        m_tx.push_back(sd[7:0]);
        tx_sb.push_back(sd[7:0]);
      end
    end
    if (w != 0 && in_mmio(da) && ofs == 3 && rx_ne_pre) tmp = m_rx.pop_front();
    if (rxv && !rx_full_pre) m_rx.push_back(rxd);
  endtask

  task automatic idle(input logic txr);
    step(32'h40, 32'h48, 64'd0, 8'h00, txr, 1'b0, 8'h00);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 7))
      0, 1, 2: a = 32'($urandom_range(0, 31) * 8 + $urandom_range(0, 7));
      3:       a = 32'(WORDS * 8 + $urandom_range(0, 31) * 8);
      4:       a = BASE + 32'h10;
      default: a = BASE + 32'($urandom_range(0, 7) * 8);
    endcase
    return a;
  endfunction

  // Monitor: compares scheduled load/fetch words and every accepted TX byte.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (tx_valid && tx_ready) begin
          if (tx_sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL tx_unexpected: got byte %h expected none", tx_data);
          end else begin
            check("tx_data", {56'd0, tx_data}, {56'd0, tx_sb.pop_front()});
          end
        end
        while (sb_q.size() > 0 && sb_q[0].due <= edge_cnt) begin
          mon_e = sb_q.pop_front();
          if (mon_e.d_mask != 0)
            check("ld_data", ld_data & mon_e.d_mask, mon_e.d & mon_e.d_mask);
          if (mon_e.i_mask != 0)
            check("ld_data_for_inst", ld_data_for_inst & mon_e.i_mask, mon_e.i & mon_e.i_mask);
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < WORDS; k++) begin m_ram[k] = '0; m_known[k] = '0; end
    m_ovf = 1'b0;
    rstn = 1'b0; pc_to_mem = '0; mem_addr = '0; st_data = '0; we = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ld_data", ld_data, 64'd0);
    check("rst_ld_inst", ld_data_for_inst, 64'd0);
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
    rstn = 1'b1;

    // Full word store, then load and fetch of the same word.
    step(32'h0, 32'h40, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, 1'b0, 8'h00);
    step(32'h40, 32'h40, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    // Partial store of offset 0; same-cycle fetch is read-first.
    step(32'h40, 32'h40, 64'hAA00_0000_0000_0000, 8'h80, 1'b0, 1'b0, 8'h00);
    step(32'h40, 32'h40, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);

    // TX overfill with the transmitter stalled, status, then drain.
    for (int i = 0; i < 17; i++)
      step(32'h40, BASE + 32'h10, 64'(i), 8'hFF, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h08, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) idle(1'b1);
    idle(1'b1);
    @(negedge clk);
    check("tx_valid_drained", {63'd0, tx_valid}, 64'd0);

    // Single RX byte, pop, and a redundant pop.
    step(32'h40, 32'h48, 64'd0, 8'h00, 1'b0, 1'b1, 8'h41);
    step(32'h40, BASE + 32'h08, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h00, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h18, 64'd0, 8'hFF, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h08, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h18, 64'd0, 8'h01, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h00, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);

    // RAM aliasing and an unmapped MMIO store.
    step(32'h40, 32'(WORDS * 8 + 32'h40), 64'hFEDC_BA98_7654_3210, 8'hFF, 1'b0, 1'b0, 8'h00);
    step(32'h40, 32'h40, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h20, 64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h20, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h08, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(32'h0, 32'h40, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);

    // RX fill past capacity, then read/pop everything back.
    for (int i = 0; i < 17; i++) step(32'h40, 32'h48, 64'd0, 8'h00, 1'b0, 1'b1, 8'(8'h80 + i));
    idle(1'b0);
    @(negedge clk);
    check("rx_ready_full", {63'd0, rx_ready}, 64'(m_rx.size() < DEPTH));
    for (int i = 0; i < 16; i++) begin
      step(32'h40, BASE + 32'h00, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
      step(32'h40, BASE + 32'h18, 64'd0, 8'hFF, 1'b0, 1'b0, 8'h00);
    end
    step(32'h40, BASE + 32'h08, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [7:0] w;
      case ($urandom_range(0, 3))
        0:       w = 8'hFF;
        1:       w = 8'($urandom);
        default: w = 8'h00;
      endcase
      step(rand_addr(), rand_addr(), {$urandom, $urandom}, w,
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    for (int n = 0; n < 40 && m_tx.size() > 0; n++) idle(1'b1);
    for (int n = 0; n < LAT + 2; n++) idle(1'b0);
    for (int n = 0; n < 10 && sb_q.size() > 0; n++) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("tx_sb_drained", 64'(tx_sb.size()), 64'd0);

    // Reset with bytes queued in both FIFOs and reads in flight.
    step(32'h40, BASE + 32'h10, 64'h5A, 8'hFF, 1'b0, 1'b1, 8'h33);
    step(32'h40, BASE + 32'h10, 64'hA5, 8'hFF, 1'b0, 1'b0, 8'h00);
    step(32'h40, 32'h40, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    sb_q.delete();
    tx_sb.delete();
    rstn = 1'b0;
    #1;
    check("mid_rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("mid_rst_ld_data", ld_data, 64'd0);
    check("mid_rst_ld_inst", ld_data_for_inst, 64'd0);
    check("mid_rst_rx_ready", {63'd0, rx_ready}, 64'd1);
    m_tx.delete(); m_rx.delete(); m_ovf = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(32'h40, BASE + 32'h08, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    step(32'h40, BASE + 32'h00, 64'd0, 8'h00, 1'b0, 1'b0, 8'h00);
    for (int n = 0; n < LAT + 2; n++) idle(1'b0);
    for (int n = 0; n < 10 && sb_q.size() > 0; n++) @(negedge clk);
    check("sb_final_drained", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
